store_unit: RTL
===============

# store_unit

Registered, parametrised store path between the MEM stage and the data memory port. It accepts one store per handshake and places the data into the correct byte lanes with a matching byte-enable mask. Stores that cross a memory-word boundary are either split into two memory beats or rejected with a misalignment fault, selected at elaboration time. This gives the pipeline a single stall/done interface in place of a purely combinational mask.

## Interface
- XLEN, 32 — data and memory word width in bits; 32 or 64.
- AW, 32 — byte-address width.
- SPLIT_MISALIGNED, 1 — 1: split boundary-crossing stores into two beats; 0: fault them.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  unit can accept a request.
- req_type  input  2  size: 00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
- req_addr  input  AW  byte address.
- req_data  input  XLEN  store data, right-justified.
- mem_write  output  1  memory write beat valid.
- mem_addr  output  AW  memory-word-aligned address; low log2(XLEN/8) bits always 0.
- mem_wdata  output  XLEN  lane-positioned write data; disabled lanes are 0.
- mem_byte_en  output  XLEN/8  byte enables.
- mem_resp  input  1  memory accepted the current beat.
- done  output  1  one-cycle pulse: the store is fully written.
- fault  output  1  one-cycle pulse: the store was rejected; no memory access was made.

## Operation
- NB = XLEN/8. OFF = req_addr[log2(NB)-1:0]. S = 1<<req_type bytes.
- Wide mask = ((1<<S)-1) << OFF, 2·NB bits. Wide data = (req_data truncated to S bytes) << 8·OFF, 2·XLEN bits.
- Beat 0 uses the low halves. Beat 1 uses the high halves, at address = aligned addr + NB (wraps mod 2^AW).
- A store crosses a word boundary when OFF + S > NB.
- A fault is raised for a crossing store when SPLIT_MISALIGNED=0, and for req_type=11 when XLEN=32.
- States:
  - IDLE: req_ready=1. On req_valid, latch type, addr and data. Faulting request: stay IDLE, pulse fault next cycle. Otherwise go to BEAT0.
  - BEAT0: mem_write=1 with beat-0 lanes. On mem_resp: go to BEAT1 if crossing, else go to IDLE and pulse done.
  - BEAT1: mem_write=1 with beat-1 lanes. On mem_resp: go to IDLE and pulse done.
- mem_addr, mem_wdata and mem_byte_en are registered and held stable while mem_write=1 until mem_resp.
- mem_resp outside BEAT0/BEAT1 is ignored.
- Reset asserted mid-store abandons the store. A beat already accepted by memory is not rolled back.

## Timing
- Reset values: req_ready=1 (IDLE); mem_write, mem_addr, mem_wdata, mem_byte_en, done and fault all 0.
- mem_write rises the cycle after request acceptance.
- Aligned store with mem_resp in the same cycle as the beat: done is high 2 cycles after acceptance.
- Split store: one extra beat, so a minimum of 3 cycles.
- done and fault are high in the cycle the FSM is back in IDLE. A new request can be accepted in that same cycle, so back-to-back throughput is one store per 2 cycles when aligned.
- Faulting request: fault is high the cycle after acceptance; req_ready stays 1 throughout.
- done and fault are never asserted together.

## Structure
- Shared package store_unit_pkg holds:
  - enum store_size_t (BYTE, HALF, WORD, DOUBLE);
  - enum store_state_t (IDLE, BEAT0, BEAT1);
  - helper function size_bytes().
- Sub-module store_lane_align, combinational and parametrised by XLEN:
  - inputs: type, offset, data;
  - outputs: 2·NB-bit mask, 2·XLEN-bit data, crossing flag.
- The top level holds the FSM and the output registers.

## Test plan
- XLEN=32, SB, addr 0x1003, data 0xA5 → one beat: mem_addr 0x1000, byte_en 1000, wdata 0xA5000000; done at cycle +2.
- XLEN=32, SH, addr 0x2002, data 0xBEEF → byte_en 1100, wdata 0xBEEF0000, one beat.
- XLEN=32, SPLIT=1, SW, addr 0x3003, data 0x11223344:
  - beat 0: mem_addr 0x3000, byte_en 1000, wdata 0x44000000;
  - beat 1: mem_addr 0x3004, byte_en 0111, wdata 0x00112233;
  - single done pulse at the end.
- XLEN=32, SPLIT=0, same store → fault pulse at +1, mem_write never asserted; XLEN=32 with type 11 also faults.
- XLEN=64, SD, addr 0x...FFF8 with AW=16, hold mem_resp low for 3 cycles:
  - outputs stable while waiting;
  - byte_en 0xFF;
  - single beat.
- Assert rst_n low during BEAT1 → next cycle: IDLE, req_ready=1, mem_write=0, no done pulse.

Source files
------------

// File: rtl/store_unit_pkg.sv
// rtl/store_unit_pkg.sv - shared types and helpers for the store path
package store_unit_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } store_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT0 = 2'b01,
        BEAT1 = 2'b10
    } store_state_t;

    function automatic int size_bytes(store_size_t size);
        return 1 << int'(size);
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - places store data and byte mask into a two-word lane window
module store_lane_align
    import store_unit_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB  = XLEN / 8,
    localparam int OW  = $clog2(NB)
) (
    input  logic [1:0]        size,
    input  logic [OW-1:0]     offset,
    input  logic [XLEN-1:0]   data,
    output logic [2*NB-1:0]   wide_mask,
    output logic [2*XLEN-1:0] wide_data,
    output logic              crossing
);

    logic [NB-1:0]   base_mask;
    logic [XLEN-1:0] base_data;
    int              nbytes;

    always_comb begin
        nbytes    = size_bytes(store_size_t'(size));
        base_mask = '0;
        base_data = '0;
        for (int i = 0; i < NB; i++) begin
            base_mask[i] = (i < nbytes);
            if (base_mask[i]) begin
                base_data[8*i +: 8] = data[8*i +: 8];
            end
        end
        wide_mask = {{NB{1'b0}}, base_mask} << offset;
        wide_data = {{XLEN{1'b0}}, base_data} << {offset, 3'b000};
        crossing  = (int'(offset) + nbytes) > NB;
    end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - registered store path with optional split of boundary-crossing stores
module store_unit
    import store_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int AW               = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_data,
    output logic              mem_write,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_en,
    input  logic              mem_resp,
    output logic              done,
    output logic              fault
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    store_state_t        state, state_next;
    logic [2*NB-1:0]     wide_mask;
    logic [2*XLEN-1:0]   wide_data;
    logic                crossing;
    logic                req_fault;
    logic [NB-1:0]       hi_mask_q;
    logic [XLEN-1:0]     hi_data_q;
    logic                cross_q;
    logic                done_next, fault_next, load_b0, load_b1, clear;

    store_lane_align #(.XLEN(XLEN)) u_align (
        .size      (req_type),
        .offset    (req_addr[OW-1:0]),
        .data      (req_data),
        .wide_mask (wide_mask),
        .wide_data (wide_data),
        .crossing  (crossing)
    );

    assign req_fault = ((store_size_t'(req_type) == DOUBLE) && (XLEN == 32))
                     || (crossing && (SPLIT_MISALIGNED == 0));
    assign req_ready = (state == IDLE);
    assign mem_write = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        fault_next = 1'b0;
        load_b0    = 1'b0;
        load_b1    = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        fault_next = 1'b1;
                    end else begin
                        state_next = BEAT0;
                        load_b0    = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (mem_resp) begin
                    if (cross_q) begin
                        state_next = BEAT1;
                        load_b1    = 1'b1;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        clear      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_resp) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The upper half of the lane window is kept for the second beat of a split store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            fault       <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= '0;
            hi_mask_q   <= '0;
            hi_data_q   <= '0;
            cross_q     <= 1'b0;
        end else begin
            done  <= done_next;
            fault <= fault_next;
            if (load_b0) begin
                mem_addr    <= {req_addr[AW-1:OW], {OW{1'b0}}};
                mem_byte_en <= wide_mask[NB-1:0];
                mem_wdata   <= wide_data[XLEN-1:0];
                hi_mask_q   <= wide_mask[2*NB-1:NB];
                hi_data_q   <= wide_data[2*XLEN-1:XLEN];
                cross_q     <= crossing;
            end else if (load_b1) begin
                mem_addr    <= mem_addr + AW'(NB);
                mem_byte_en <= hi_mask_q;
                mem_wdata   <= hi_data_q;
            end else if (clear) begin
                mem_addr    <= '0;
                mem_byte_en <= '0;
                mem_wdata   <= '0;
            end
        end
    end

endmodule
